// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline memory/writeback stage.
// Includes the misalignment predicate used when MISALIGN_CHECK_EN is defined.
package pipe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic res;
    res = 1'b0;
    if (size == SZ_H) res = lane[0];
    else if (size != SZ_B) res = (lane != 2'b00);
    return res;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables and data replication,
// plus load lane extraction with sign/zero extension.
module load_store_align
  import pipe_pkg::*;
(
  input  logic [1:0]      i_st_size,
  input  logic [1:0]      i_st_lane,
  input  logic [XLEN-1:0] i_st_data,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_lane,
  input  logic [XLEN-1:0] i_ld_data,
  output logic [XLEN-1:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_st_lane;
        o_wdata = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        o_be    = 4'b0011 << {i_st_lane[1], 1'b0};
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_lane)
      2'd0:    w_ld_byte = i_ld_data[7:0];
      2'd1:    w_ld_byte = i_ld_data[15:8];
      2'd2:    w_ld_byte = i_ld_data[23:16];
      default: w_ld_byte = i_ld_data[31:24];
    endcase
    w_ld_half = i_ld_lane[1] ? i_ld_data[31:16] : i_ld_data[15:0];
  end

  // funct3[2] selects zero extension (lbu/lhu)
  always_comb begin
    o_ld_data = i_ld_data;
    case (i_ld_funct3[1:0])
      SZ_B: o_ld_data = i_ld_funct3[2] ? {24'b0, w_ld_byte}
                                       : {{24{w_ld_byte[7]}}, w_ld_byte};
      SZ_H: o_ld_data = i_ld_funct3[2] ? {16'b0, w_ld_half}
                                       : {{16{w_ld_half[15]}}, w_ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: data-memory valid/ack handshake, lane alignment, writeback mux.
// Optional macro MISALIGN_CHECK_EN turns misaligned half/word accesses into a one-cycle exception.
module mem_wb_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr_in,
  input  logic        wr_en_in,
  input  logic        rd_en_in,
  input  logic [1:0]  wb_sel_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] csr_rdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall,
  output logic        misalign_exc
);

  mem_state_e  r_state;
  mem_state_e  w_state_next;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd_addr;
  logic        r_reg_wr;

  logic        w_mem_op;
  logic        w_issue;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic [31:0] w_wb_data;

  assign w_mem_op = rd_en_in | wr_en_in;

`ifdef MISALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign;

  assign w_misalign   = w_mem_op && is_misaligned(funct3_in[1:0], alu_result_in[1:0]);
  assign w_issue      = w_mem_op && !w_misalign;
  assign misalign_exc = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= (r_state == IDLE) && w_misalign;
  end
`else
  assign w_issue      = w_mem_op;
  assign misalign_exc = 1'b0;
`endif

  load_store_align u_align (
    .i_st_size   (funct3_in[1:0]),
    .i_st_lane   (alu_result_in[1:0]),
    .i_st_data   (store_data_in),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_lane   (r_lane),
    .i_ld_data   (mem_rdata),
    .o_ld_data   (w_ld_data)
  );

  always_comb begin
    case (wb_sel_e'(wb_sel_in))
      WB_MEM:  w_wb_data = w_ld_data;
      WB_PC4:  w_wb_data = pc_plus4_in;
      WB_CSR:  w_wb_data = csr_rdata_in;
      default: w_wb_data = alu_result_in;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          stall        = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        stall = !mem_ack;
        if (mem_ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // rf_we is a single-cycle pulse; address/data hold their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
      mem_be    <= 4'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'b0;
      rf_wdata  <= 32'b0;
      r_funct3  <= 3'b0;
      r_lane    <= 2'b0;
      r_rd_addr <= 5'b0;
      r_reg_wr  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= wr_en_in;
            mem_addr  <= {alu_result_in[31:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
            r_funct3  <= funct3_in;
            r_lane    <= alu_result_in[1:0];
            r_rd_addr <= rd_addr_in;
            r_reg_wr  <= reg_wr_in;
          end else if (!w_mem_op) begin
            rf_we    <= reg_wr_in && (rd_addr_in != 5'd0);
            rf_waddr <= rd_addr_in;
            rf_wdata <= w_wb_data;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rf_we    <= r_reg_wr && (r_rd_addr != 5'd0);
              rf_waddr <= r_rd_addr;
              rf_wdata <= w_ld_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table plus scoreboard of register-file writes.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr_in, wr_en_in, rd_en_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_result_in, store_data_in, pc_plus4_in, csr_rdata_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall, misalign_exc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .reg_wr_in(reg_wr_in), .wr_en_in(wr_en_in), .rd_en_in(rd_en_in),
    .wb_sel_in(wb_sel_in), .funct3_in(funct3_in), .rd_addr_in(rd_addr_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .pc_plus4_in(pc_plus4_in), .csr_rdata_in(csr_rdata_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall(stall), .misalign_exc(misalign_exc)
  );

  typedef struct {
    logic        rd, wr, reg_wr;
    logic [1:0]  wb;
    logic [2:0]  f3;
    logic [4:0]  rd_addr;
    logic [31:0] alu, sdata, pc4, csr, rdata;
    int          dly;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        chk_data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic        chk_mw;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        chk;
  } rf_exp_t;

  rf_exp_t sb_q[$];
  vec_t    vecs[17];

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_alu(input logic reg_wr, input logic [1:0] wb, input logic [4:0] rd,
                                  input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] csr,
                                  input logic exp_we, input logic [31:0] exp_wdata);
    vec_t v;
    v = '{rd: 1'b0, wr: 1'b0, reg_wr: reg_wr, wb: wb, f3: 3'b010, rd_addr: rd,
          alu: alu, sdata: 32'h0, pc4: pc4, csr: csr, rdata: 32'h0, dly: 0,
          exp_we: exp_we, exp_wdata: exp_wdata, chk_data: 1'b1,
          exp_addr: 32'h0, exp_be: 4'h0, exp_mwdata: 32'h0, chk_mw: 1'b0};
    return v;
  endfunction

  function automatic vec_t mk_mem(input logic rd, input logic wr, input logic reg_wr, input logic [2:0] f3,
                                  input logic [4:0] rd_addr, input logic [31:0] alu, input logic [31:0] sdata,
                                  input logic [31:0] rdata, input int dly,
                                  input logic exp_we, input logic [31:0] exp_wdata, input logic chk_data,
                                  input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                  input logic [31:0] exp_mwdata, input logic chk_mw);
    vec_t v;
    v = '{rd: rd, wr: wr, reg_wr: reg_wr, wb: 2'b01, f3: f3, rd_addr: rd_addr,
          alu: alu, sdata: sdata, pc4: 32'h0, csr: 32'h0, rdata: rdata, dly: dly,
          exp_we: exp_we, exp_wdata: exp_wdata, chk_data: chk_data,
          exp_addr: exp_addr, exp_be: exp_be, exp_mwdata: exp_mwdata, chk_mw: chk_mw};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rd_en_in      = v.rd;
    wr_en_in      = v.wr;
    reg_wr_in     = v.reg_wr;
    wb_sel_in     = v.wb;
    funct3_in     = v.f3;
    rd_addr_in    = v.rd_addr;
    alu_result_in = v.alu;
    store_data_in = v.sdata;
    pc_plus4_in   = v.pc4;
    csr_rdata_in  = v.csr;
  endtask

  task automatic drive_nop();
    rd_en_in = 1'b0; wr_en_in = 1'b0; reg_wr_in = 1'b0; wb_sel_in = 2'b00;
    funct3_in = 3'b000; rd_addr_in = 5'd0; alu_result_in = 32'h0;
    store_data_in = 32'h0; pc_plus4_in = 32'h0; csr_rdata_in = 32'h0;
  endtask

  task automatic pop_check(input string tag);
    rf_exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty: got no expected entry want one", tag);
    end else begin
      e = sb_q.pop_front();
      check1({tag, "_rf_we"}, rf_we, e.we);
      if (e.chk) begin
        check32({tag, "_rf_waddr"}, {27'b0, rf_waddr}, {27'b0, e.waddr});
        check32({tag, "_rf_wdata"}, rf_wdata, e.wdata);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the transaction.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v);
    sb_q.push_back('{we: v.exp_we, waddr: v.rd_addr, wdata: v.exp_wdata, chk: v.chk_data});
    if (!(v.rd || v.wr)) begin
      @(negedge clk);
      check1({tag, "_stall"}, stall, 1'b0);
      @(posedge clk); #1;
      pop_check(tag);
    end else begin
      @(negedge clk);
      check1({tag, "_stall_c0"}, stall, 1'b1);
      @(posedge clk); #1;
      check1({tag, "_mem_req"}, mem_req, 1'b1);
      check1({tag, "_mem_we"}, mem_we, v.wr);
      check32({tag, "_mem_addr"}, mem_addr, v.exp_addr);
      check32({tag, "_mem_be"}, {28'b0, mem_be}, {28'b0, v.exp_be});
      if (v.chk_mw) check32({tag, "_mem_wdata"}, mem_wdata, v.exp_mwdata);
      for (int c = 1; c < v.dly; c++) begin
        @(negedge clk);
        check1({tag, "_stall_wait"}, stall, 1'b1);
        @(posedge clk); #1;
        check1({tag, "_req_hold"}, mem_req, 1'b1);
        check32({tag, "_addr_hold"}, mem_addr, v.exp_addr);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      check1({tag, "_stall_ack"}, stall, 1'b0);
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      check1({tag, "_req_clr"}, mem_req, 1'b0);
      pop_check(tag);
    end
    $display("txn %0d rd=%b wr=%b addr=%h rf_we=%b rf_waddr=%0d rf_wdata=%h", idx, v.rd, v.wr,
             v.alu, rf_we, rf_waddr, rf_wdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk_alu(1'b1, 2'b00, 5'd5,  32'h0000_1234, 32'h0, 32'h0, 1'b1, 32'h0000_1234);
    vecs[1]  = mk_alu(1'b1, 2'b10, 5'd1,  32'h0000_DEAD, 32'h0000_0104, 32'h0, 1'b1, 32'h0000_0104);
    vecs[2]  = mk_alu(1'b1, 2'b11, 5'd31, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
    vecs[3]  = mk_alu(1'b1, 2'b00, 5'd0,  32'h0000_0055, 32'h0, 32'h0, 1'b0, 32'h0000_0055);
    vecs[4]  = mk_alu(1'b0, 2'b00, 5'd7,  32'h0000_0077, 32'h0, 32'h0, 1'b0, 32'h0000_0077);
    vecs[5]  = mk_mem(1'b0, 1'b1, 1'b0, 3'b000, 5'd0,  32'h103, 32'h0000_00AB, 32'h0, 1,
                      1'b0, 32'h0, 1'b0, 32'h100, 4'b1000, 32'hABAB_ABAB, 1'b1);
    vecs[6]  = mk_mem(1'b1, 1'b0, 1'b1, 3'b000, 5'd9,  32'h102, 32'h0, 32'h0080_0000, 3,
                      1'b1, 32'hFFFF_FF80, 1'b1, 32'h100, 4'b0100, 32'h0, 1'b0);
    vecs[7]  = mk_mem(1'b1, 1'b0, 1'b1, 3'b100, 5'd9,  32'h102, 32'h0, 32'h0080_0000, 1,
                      1'b1, 32'h0000_0080, 1'b1, 32'h100, 4'b0100, 32'h0, 1'b0);
    vecs[8]  = mk_mem(1'b1, 1'b0, 1'b1, 3'b010, 5'd0,  32'h200, 32'h0, 32'h1234_5678, 1,
                      1'b0, 32'h0, 1'b0, 32'h200, 4'b1111, 32'h0, 1'b0);
    vecs[9]  = mk_mem(1'b1, 1'b0, 1'b1, 3'b001, 5'd3,  32'h202, 32'h0, 32'h8001_0000, 2,
                      1'b1, 32'hFFFF_8001, 1'b1, 32'h200, 4'b1100, 32'h0, 1'b0);
    vecs[10] = mk_mem(1'b1, 1'b0, 1'b1, 3'b101, 5'd3,  32'h200, 32'h0, 32'h1234_F00F, 1,
                      1'b1, 32'h0000_F00F, 1'b1, 32'h200, 4'b0011, 32'h0, 1'b0);
    vecs[11] = mk_mem(1'b0, 1'b1, 1'b1, 3'b001, 5'd2,  32'h302, 32'h1234_ABCD, 32'h0, 1,
                      1'b0, 32'h0, 1'b0, 32'h300, 4'b1100, 32'hABCD_ABCD, 1'b1);
    vecs[12] = mk_mem(1'b0, 1'b1, 1'b0, 3'b010, 5'd0,  32'h400, 32'hDEAD_BEEF, 32'h0, 2,
                      1'b0, 32'h0, 1'b0, 32'h400, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    vecs[13] = mk_mem(1'b1, 1'b0, 1'b1, 3'b000, 5'd10, 32'h101, 32'h0, 32'h0000_7F00, 1,
                      1'b1, 32'h0000_007F, 1'b1, 32'h100, 4'b0010, 32'h0, 1'b0);
    vecs[14] = mk_mem(1'b1, 1'b0, 1'b0, 3'b010, 5'd4,  32'h104, 32'h0, 32'hA5A5_A5A5, 1,
                      1'b0, 32'h0, 1'b0, 32'h104, 4'b1111, 32'h0, 1'b0);
    vecs[15] = mk_mem(1'b1, 1'b1, 1'b1, 3'b000, 5'd11, 32'h000, 32'h0000_0011, 32'h9999_9999, 1,
                      1'b0, 32'h0, 1'b0, 32'h000, 4'b0001, 32'h1111_1111, 1'b1);
    vecs[16] = mk_mem(1'b1, 1'b0, 1'b1, 3'b010, 5'd6,  32'h104, 32'h0, 32'h89AB_CDEF, 1,
                      1'b1, 32'h89AB_CDEF, 1'b1, 32'h104, 4'b1111, 32'h0, 1'b0);

    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive_nop();
    @(posedge clk); @(posedge clk); #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check32("rst_mem_be", {28'b0, mem_be}, 32'h0);
    check1("rst_rf_we", rf_we, 1'b0);
    check32("rst_rf_waddr", {27'b0, rf_waddr}, 32'h0);
    check32("rst_rf_wdata", rf_wdata, 32'h0);
    check1("rst_misalign", misalign_exc, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("idle_stall", stall, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Reset while a request is outstanding, then a late ack in IDLE
    drive(mk_mem(1'b1, 1'b0, 1'b1, 3'b010, 5'd12, 32'h010, 32'h0, 32'h0, 1,
                 1'b0, 32'h0, 1'b0, 32'h010, 4'b1111, 32'h0, 1'b0));
    @(posedge clk); #1;
    check1("mrst_req_up", mem_req, 1'b1);
    rst = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    check1("mrst_req_clr", mem_req, 1'b0);
    check32("mrst_addr_clr", mem_addr, 32'h0);
    check1("mrst_stall", stall, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    check1("late_ack_req", mem_req, 1'b0);
    check1("late_ack_rf_we", rf_we, 1'b0);
    check1("late_ack_stall", stall, 1'b0);
    $display("txn reset_mid_req mem_req=%b rf_we=%b", mem_req, rf_we);

    // Misaligned word load at 0x102
`ifdef MISALIGN_CHECK_EN
    drive(mk_mem(1'b1, 1'b0, 1'b1, 3'b010, 5'd8, 32'h102, 32'h0, 32'h0, 1,
                 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0));
    @(negedge clk);
    check1("mis_stall", stall, 1'b0);
    @(posedge clk); #1;
    check1("mis_req", mem_req, 1'b0);
    check1("mis_exc", misalign_exc, 1'b1);
    check1("mis_rf_we", rf_we, 1'b0);
    drive_nop();
    @(posedge clk); #1;
    check1("mis_exc_pulse", misalign_exc, 1'b0);
    check1("mis_req_after", mem_req, 1'b0);
    $display("txn misaligned_lw exc_pulse_checked");
`else
    run_vec(mk_mem(1'b1, 1'b0, 1'b1, 3'b010, 5'd8, 32'h102, 32'h0, 32'hA5A5_A5A5, 1,
                   1'b1, 32'hA5A5_A5A5, 1'b1, 32'h100, 4'b1111, 32'h0, 1'b0), 17);
    check1("mis_exc_off", misalign_exc, 1'b0);
    drive_nop();
`endif

    check32("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
